ahb_sram_bridge: RTL and testbench

AHB-Lite subordinate that acts as the initiator for a single-port synchronous SRAM with byte write enables and one-cycle read latency (the SRAM macro or its simulation view).
- Zero-wait-state bridge: reads access the SRAM in the AHB address phase.
- Writes go to the SRAM in the data phase. If a read address phase collides, the write is held in a one-entry write buffer and forwarded to later reads.
- Sits between the AHB interconnect and each on-chip code/data SRAM bank.

---
 rtl/ahb_sram_pkg.sv | 32 +++
 rtl/ahb_sram_wbuf.sv | 93 +++++++++
 rtl/ahb_sram_bridge.sv | 173 +++++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared definitions for the AHB-Lite to SRAM bridge.
//   - AHB HTRANS and HSIZE encodings
//   - byte_strb(): little-endian byte-lane strobes from HSIZE and HADDR[1:0]
//   - err_state_t: state type of the optional error-response FSM
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef logic [1:0] err_state_t;
  localparam err_state_t ST_IDLE = 2'd0;
  localparam err_state_t ST_ERR1 = 2'd1;
  localparam err_state_t ST_ERR2 = 2'd2;

  // Low address bits beyond the transfer size are ignored, which aligns
  // misaligned halfwords down. Sizes above a word fall into the word case.
  function automatic logic [3:0] byte_strb(input logic [2:0] size,
                                           input logic [1:0] a);
    case (size)
      HSIZE_BYTE: byte_strb = 4'b0001 << a;
      HSIZE_HALF: byte_strb = 4'b0011 << {a[1], 1'b0};
      default:    byte_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// ahb_sram_wbuf: one-entry write buffer for the AHB-SRAM bridge.
// Holds a write that lost the SRAM port to a read, and merges its bytes
// into read data returned for the same word.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i               capture addr_i/strb_i/data_i, set valid
//   drain_i              the buffered write is going to the SRAM; clear valid
//   addr_i/strb_i/data_i write to capture
//   rd_addr_i            word address of the read in its data phase
//   rd_data_i            raw SRAM read data
//   valid_o/addr_o/strb_o/data_o  buffer contents (drive the SRAM on drain)
//   merged_o             rd_data_i with buffered bytes overlaid on address match
module ahb_sram_wbuf
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            strb_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [3:0]            strb_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] merged_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            strb_q, strb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      strb_d  = strb_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
    end
  end

  // The buffered write is younger than the SRAM contents, so its bytes win.
  always_comb begin
    merged_o = rd_data_i;
    if (valid_q && (addr_q == rd_addr_i)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) merged_o[8*b +: 8] = data_q[8*b +: 8];
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign strb_o  = strb_q;
  assign data_o  = data_q;

`ifndef SYNTHESIS
  // A load only happens in a write data phase, whose address phase already
  // drained the buffer; so a load never meets a drain or a full buffer.
  a_no_load_drain: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(load_i && drain_i));
  a_no_load_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(load_i && valid_q));
`endif

endmodule

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: zero-wait-state AHB-Lite subordinate driving a
// single-port synchronous SRAM (byte write enables, 1-cycle read latency).
// Reads use the SRAM in the address phase; writes use it in the data phase.
// A write whose data phase meets a read address phase is parked in a
// one-entry buffer, drained on the next cycle without a read.
// Build option: define AHA_SRAM_BRIDGE_ERR_EN to answer misaligned
// accesses and HSIZE>2 with a two-cycle ERROR response; without it low
// address bits are ignored and no error is ever returned.
// Ports:
//   CLK, RESETn                 clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY   AHB-Lite inputs
//   HREADYOUT/HRESP/HRDATA      AHB-Lite outputs
//   SRAM_CS/SRAM_WE/SRAM_ADDR/SRAM_WDATA  SRAM request
//   SRAM_RDATA                  SRAM read data, valid one cycle after a read
module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH+1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  SRAM_CS,
  output logic [3:0]            SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
);

  logic acc, bad, acc_ok, rd_acc;
  logic wr_dp, rd_dp, wb_load, wb_drain;

  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]            dp_strb_q, dp_strb_d;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [3:0]            wb_strb;
  logic [DATA_WIDTH-1:0] wb_data, rd_merged;

  assign acc = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

`ifdef AHA_SRAM_BRIDGE_ERR_EN
  assign bad = (HSIZE > HSIZE_WORD)
             | ((HSIZE == HSIZE_HALF) & HADDR[0])
             | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));
`else
  assign bad = 1'b0;
`endif

  assign acc_ok = acc & ~bad;
  assign rd_acc = acc_ok & ~HWRITE;

  // Data-phase registers advance only when the bus advances.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_strb_d  = dp_strb_q;
    if (HREADY) begin
      dp_valid_d = acc_ok;
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[ADDR_WIDTH+1:2];
      dp_strb_d  = byte_strb(HSIZE, HADDR[1:0]);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_strb_q  <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_strb_q  <= dp_strb_d;
    end
  end

  assign wr_dp    = dp_valid_q & dp_write_q;
  assign rd_dp    = dp_valid_q & ~dp_write_q;
  assign wb_load  = wr_dp & rd_acc;
  assign wb_drain = wb_valid & ~rd_acc & ~wr_dp;

  ahb_sram_wbuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk_i    (CLK),
    .rst_ni   (RESETn),
    .load_i   (wb_load),
    .drain_i  (wb_drain),
    .addr_i   (dp_addr_q),
    .strb_i   (dp_strb_q),
    .data_i   (HWDATA),
    .rd_addr_i(dp_addr_q),
    .rd_data_i(SRAM_RDATA),
    .valid_o  (wb_valid),
    .addr_o   (wb_addr),
    .strb_o   (wb_strb),
    .data_o   (wb_data),
    .merged_o (rd_merged)
  );

  // One SRAM access per cycle: read address phase, then direct write,
  // then buffer drain.
  always_comb begin
    SRAM_CS    = 1'b0;
    SRAM_WE    = 4'b0000;
    SRAM_ADDR  = dp_addr_q;
    SRAM_WDATA = HWDATA;
    if (rd_acc) begin
      SRAM_CS   = 1'b1;
      SRAM_ADDR = HADDR[ADDR_WIDTH+1:2];
    end else if (wr_dp) begin
      SRAM_CS = 1'b1;
      SRAM_WE = dp_strb_q;
    end else if (wb_valid) begin
      SRAM_CS    = 1'b1;
      SRAM_WE    = wb_strb;
      SRAM_ADDR  = wb_addr;
      SRAM_WDATA = wb_data;
    end
    // The address-phase path is combinational from the bus; keep the
    // macro quiet while reset is held.
    if (!RESETn) begin
      SRAM_CS = 1'b0;
      SRAM_WE = 4'b0000;
    end
  end

  assign HRDATA = rd_dp ? rd_merged : '0;

`ifdef AHA_SRAM_BRIDGE_ERR_EN
  err_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc & bad) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // HREADY is high in ERR2, so a new rejected transfer may start here.
      default: state_d = (acc & bad) ? ST_ERR1 : ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q != ST_IDLE);
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_bridge.sv
`timescale 1ns/1ps
module tb_ahb_sram_bridge;

  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          HSEL;
  logic [AW+1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic          SRAM_CS;
  logic [3:0]    SRAM_WE;
  logic [AW-1:0] SRAM_ADDR;
  logic [31:0]   SRAM_WDATA;
  logic [31:0]   SRAM_RDATA;

  always #5 CLK = ~CLK;

  // Single subordinate on the bus: HREADY follows our own HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb_sram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA)
  );

  // SRAM macro simulation view.
  logic [31:0] sram    [0:(1<<AW)-1];
  // Reference: memory contents in bus order, as the AHB master sees them.
  logic [31:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge CLK) begin
    if (SRAM_CS) begin
      if (SRAM_WE == 4'b0000) SRAM_RDATA <= sram[SRAM_ADDR];
      else sram[SRAM_ADDR] = lane_merge(sram[SRAM_ADDR], SRAM_WDATA, SRAM_WE);
    end
  end

  int total = 0;
  int nbad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference write: a transfer of N bytes covers N naturally aligned lanes.
  task automatic ref_write(input logic [14:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n, off;
    n   = (sz > 3'd2) ? 4 : (1 << sz);
    off = int'(a[1:0]);
    off = off - (off % n);
    for (int k = off; k < off + n; k++) ref_mem[a[14:2]][8*k +: 8] = d[8*k +: 8];
  endtask

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [14:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        chk_mem;
    logic        cs;
    logic [3:0]  we;
    logic [12:0] maddr;
    logic [31:0] mwdata;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t t_w(input logic [14:0] a, input logic [2:0] sz, input logic [31:0] d);
    vec_t v;
    v = '0; v.sel = 1'b1; v.wr = 1'b1; v.addr = a; v.size = sz; v.wdata = d;
    return v;
  endfunction
  function automatic vec_t t_r(input logic [14:0] a, input logic [2:0] sz);
    vec_t v;
    v = '0; v.sel = 1'b1; v.addr = a; v.size = sz;
    return v;
  endfunction
  function automatic vec_t t_i();
    vec_t v;
    v = '0;
    return v;
  endfunction
  function automatic vec_t e_m(input vec_t vi, input logic cs, input logic [3:0] we,
                               input logic [12:0] ma, input logic [31:0] md);
    vec_t v;
    v = vi; v.chk_mem = 1'b1; v.cs = cs; v.we = we; v.maddr = ma; v.mwdata = md;
    return v;
  endfunction
  function automatic vec_t e_r(input vec_t vi, input logic [31:0] d);
    vec_t v;
    v = vi; v.chk_rd = 1'b1; v.rdata = d;
    return v;
  endfunction

  // Bus pipeline bookkeeping for the transfer in its data phase.
  logic        pend_rd = 1'b0;
  logic [31:0] pend_exp = '0;
  logic [31:0] pend_wd = '0;

  task automatic step(input vec_t v);
    HSEL   = v.sel;
    HTRANS = v.sel ? 2'b10 : 2'b00;
    HWRITE = v.wr;
    HADDR  = v.addr;
    HSIZE  = v.size;
    HWDATA = pend_wd;
    @(negedge CLK);
    chk("hrdata", HRDATA, pend_rd ? pend_exp : 32'h0);
    chk("ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);
    if (v.chk_mem) begin
      chk("sram_cs", {31'b0, SRAM_CS}, {31'b0, v.cs});
      if (v.cs) begin
        chk("sram_we", {28'b0, SRAM_WE}, {28'b0, v.we});
        chk("sram_addr", {19'b0, SRAM_ADDR}, {19'b0, v.maddr});
        if (v.we != 4'b0000) chk("sram_wdata", SRAM_WDATA, v.mwdata);
      end
    end
    if (v.chk_rd) chk("tbl_rdata", HRDATA, v.rdata);
    pend_rd = v.sel && !v.wr;
    if (v.sel && v.wr) begin
      ref_write(v.addr, v.size, v.wdata);
      pend_wd = v.wdata;
    end else begin
      pend_wd = 32'h0;
    end
    if (pend_rd) pend_exp = ref_mem[v.addr[14:2]];
    @(posedge CLK); #1;
  endtask

  function automatic logic [14:0] rand_addr(input logic [2:0] sz);
    logic [12:0] w;
    logic [1:0]  off;
    w   = 13'(32 + $urandom_range(0, 7));
    off = 2'($urandom_range(0, 3));
    if (sz == 3'd1) off[0] = 1'b0;
    if (sz == 3'd2) off = 2'b00;
    return {w, off};
  endfunction

  vec_t        tbl[$];
  vec_t        v;
  logic [31:0] old;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      old = $urandom;
      sram[i]    = old;
      ref_mem[i] = old;
    end

    // Reset, with a read address phase presented on the bus.
    RESETn = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 15'h10; HSIZE = 3'd2; HWDATA = '0;
    @(posedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_cs", {31'b0, SRAM_CS}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);
    HSEL = 1'b0; HTRANS = 2'b00;
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // Directed vectors, one bus cycle each.
    tbl.push_back(e_m(t_w(15'h10, 3'd2, 32'hDEADBEEF), 1'b0, 4'h0, 13'h0, 32'h0));
    tbl.push_back(e_m(t_i(), 1'b1, 4'hF, 13'h4, 32'hDEADBEEF));
    tbl.push_back(e_m(t_r(15'h10, 3'd2), 1'b1, 4'h0, 13'h4, 32'h0));
    tbl.push_back(e_m(e_r(t_i(), 32'hDEADBEEF), 1'b0, 4'h0, 13'h0, 32'h0));
    tbl.push_back(t_w(15'h20, 3'd2, 32'h11223344));
    tbl.push_back(e_m(t_r(15'h20, 3'd2), 1'b1, 4'h0, 13'h8, 32'h0));
    tbl.push_back(e_m(e_r(t_i(), 32'h11223344), 1'b1, 4'hF, 13'h8, 32'h11223344));
    tbl.push_back(t_w(15'h30, 3'd2, 32'h55667788));
    tbl.push_back(e_m(t_w(15'h33, 3'd0, 32'hAB000000), 1'b1, 4'hF, 13'hC, 32'h55667788));
    tbl.push_back(e_m(t_r(15'h30, 3'd2), 1'b1, 4'h0, 13'hC, 32'h0));
    tbl.push_back(e_m(e_r(t_i(), 32'hAB667788), 1'b1, 4'b1000, 13'hC, 32'hAB000000));
    tbl.push_back(e_m(t_i(), 1'b0, 4'h0, 13'h0, 32'h0));
    tbl.push_back(t_w(15'h12, 3'd1, 32'h12340000));
    tbl.push_back(e_m(t_i(), 1'b1, 4'b1100, 13'h4, 32'h12340000));
    tbl.push_back(t_r(15'h10, 3'd2));
    tbl.push_back(e_r(t_i(), 32'h1234BEEF));
    tbl.push_back(t_w(15'h11, 3'd0, 32'h00005600));
    tbl.push_back(e_m(t_r(15'h10, 3'd2), 1'b1, 4'h0, 13'h4, 32'h0));
    tbl.push_back(e_m(e_r(t_i(), 32'h123456EF), 1'b1, 4'b0010, 13'h4, 32'h00005600));
    tbl.push_back(t_i());
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

`ifdef AHA_SRAM_BRIDGE_ERR_EN
    // Misaligned word, then oversize: two-cycle ERROR, SRAM untouched.
    for (int c = 0; c < 2; c++) begin
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
      HADDR = (c == 0) ? 15'h2 : 15'h8;
      HSIZE = (c == 0) ? 3'd2 : 3'd3;
      HWDATA = '0;
      @(negedge CLK);
      chk("err_ap_cs", {31'b0, SRAM_CS}, 32'h0);
      @(posedge CLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h600DCAFE;
      @(negedge CLK);
      chk("err1_ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h1);
      chk("err1_cs", {31'b0, SRAM_CS}, 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("err2_ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h3);
      chk("err2_cs", {31'b0, SRAM_CS}, 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("err_done_ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);
      @(posedge CLK); #1;
    end
`else
    // Low bits ignored: misaligned word lands on word 0, oversize acts as word.
    step(t_w(15'h2, 3'd2, 32'h600DCAFE));
    step(e_m(t_i(), 1'b1, 4'hF, 13'h0, 32'h600DCAFE));
    step(t_w(15'h8, 3'd3, 32'h0BB00BB0));
    step(e_m(t_i(), 1'b1, 4'hF, 13'h2, 32'h0BB00BB0));
`endif

    // Alternating write/read stream, then a random mix with idles.
    for (int i = 0; i < 16; i++) begin
      v = '0;
      v.sel = 1'b1;
      v.wr = (i % 2 == 0);
      v.size = 3'($urandom_range(0, 2));
      v.addr = rand_addr(v.size);
      v.wdata = $urandom;
      step(v);
    end
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 3);
      v = '0;
      v.sel = (r != 0);
      v.wr = (r == 1);
      v.size = 3'($urandom_range(0, 2));
      v.addr = rand_addr(v.size);
      v.wdata = $urandom;
      step(v);
    end
    step(t_i());
    step(t_i());
    for (int w = 0; w < 48; w++) chk($sformatf("mem[%0d]", w), sram[w], ref_mem[w]);

    // Reset while a write sits in the buffer: it must be lost.
    step(t_w(15'h50, 3'd2, 32'h0BADF00D));
    step(t_i());
    old = ref_mem[20];
    step(t_w(15'h50, 3'd2, 32'hCAFEF00D));
    step(e_m(t_r(15'h54, 3'd2), 1'b1, 4'h0, 13'h15, 32'h0));
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 15'h50; HSIZE = 3'd2;
    #2 RESETn = 1'b0;
    #1;
    chk("rstwb_cs", {31'b0, SRAM_CS}, 32'h0);
    chk("rstwb_hrdata", HRDATA, 32'h0);
    chk("rstwb_ready_resp", {30'b0, HREADYOUT, HRESP}, 32'h2);
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    ref_mem[20] = old;
    pend_rd = 1'b0;
    pend_wd = 32'h0;
    step(t_r(15'h50, 3'd2));
    step(e_m(e_r(t_i(), 32'h0BADF00D), 1'b0, 4'h0, 13'h0, 32'h0));
    step(t_i());
    chk("rstwb_mem", sram[20], 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
